// File: rtl/pdm_capture_pkg.sv
// rtl/pdm_capture_pkg.sv - shared types and defaults for the PDM capture controller
package pdm_capture_pkg;

    localparam int DEFAULT_WORD_LENGTH = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DRAIN   = 2'd2
    } capture_state_t;

endpackage

// File: rtl/pdm_capture_controller_word_fifo.sv
// rtl/pdm_capture_controller_word_fifo.sv - word FIFO, no fall-through, flushable
// Ports: clock_i/reset_ni; push_i+data_i write; pop_i reads head data_o;
//        flush_i empties at once; full_o/empty_o status.
module word_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic             clock_i,
    input  logic             reset_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    input  logic             flush_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Extra wrap bit distinguishes full (wrap differs) from empty (identical).
    assign empty_o = (wr_ptr == rd_ptr);
    assign full_o  = (wr_ptr[AW] != rd_ptr[AW]) &&
                     (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    // A push into a full FIFO is legal when the head leaves in the same cycle.
    assign do_push = push_i && (!full_o || pop_i);
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clock_i) begin
        if (do_push && !flush_i) mem[wr_ptr[AW-1:0]] <= data_i;
    end

    // Memory is not reset; masking keeps the head at zero while nothing is stored.
    assign data_o = empty_o ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/pdm_capture_controller.sv
// rtl/pdm_capture_controller.sv - sequences one PDM recording into a buffered word stream
// Ports: start_i/stop_i/length_i commands; busy_o/done_o/overflow_o/words_captured_o status;
//        deser_enable_o/deser_done_i/deser_data_i deserializer side;
//        data_o/valid_o/ready_i downstream stream.
module pdm_capture_controller
    import pdm_capture_pkg::*;
#(
    parameter int WORD_LENGTH = DEFAULT_WORD_LENGTH,
    parameter int FIFO_DEPTH  = 8,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clock_i,
    input  logic                   reset_ni,
    input  logic                   start_i,
    input  logic                   stop_i,
    input  logic [COUNT_WIDTH-1:0] length_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   overflow_o,
    output logic [COUNT_WIDTH-1:0] words_captured_o,
    output logic                   deser_enable_o,
    input  logic                   deser_done_i,
    input  logic [WORD_LENGTH-1:0] deser_data_i,
    output logic [WORD_LENGTH-1:0] data_o,
    output logic                   valid_o,
    input  logic                   ready_i
);

    capture_state_t         state_q;
    capture_state_t         state_d;
    logic [COUNT_WIDTH-1:0] length_q;
    logic [COUNT_WIDTH-1:0] count_q;
    logic [COUNT_WIDTH-1:0] count_inc;
    logic                   overflow_q;
    logic                   done_q;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   capture_evt;
    logic                   pop;
    logic                   push;
    logic                   drop;
    logic                   flush;
    logic                   start_acc;

    assign valid_o     = !fifo_empty;
    assign pop         = valid_o && ready_i;
    assign capture_evt = (state_q == CAPTURE) && deser_done_i;
    assign push        = capture_evt && (!fifo_full || pop);
    assign drop        = capture_evt && fifo_full && !pop;
    assign flush       = (state_q == DRAIN) && stop_i;
    assign start_acc   = (state_q == IDLE) && start_i;
    assign count_inc   = (count_q == '1) ? count_q : count_q + 1'b1;

    word_fifo #(
        .WIDTH (WORD_LENGTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock_i  (clock_i),
        .reset_ni (reset_ni),
        .push_i   (push),
        .data_i   (deser_data_i),
        .pop_i    (pop),
        .flush_i  (flush),
        .data_o   (data_o),
        .full_o   (fifo_full),
        .empty_o  (fifo_empty)
    );

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start_i) state_d = CAPTURE;
            end
            CAPTURE: begin
                if (stop_i) begin
                    state_d = DRAIN;
                end else if (push && (length_q != '0) && (count_inc == length_q)) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                // A stop flushes this cycle, so the FIFO is empty when IDLE is reached.
                if (stop_i || fifo_empty) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy_o         = (state_q != IDLE);
        deser_enable_o = (state_q == CAPTURE);
    end

    // done_o is registered so it coincides with the first IDLE cycle, where busy_o is low.
    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            length_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= (state_q == DRAIN) && (state_d == IDLE);
            if (start_acc) begin
                length_q   <= length_i;
                count_q    <= '0;
                overflow_q <= 1'b0;
            end else begin
                if (push) count_q    <= count_inc;
                if (drop) overflow_q <= 1'b1;
            end
        end
    end

    assign done_o           = done_q;
    assign overflow_o       = overflow_q;
    assign words_captured_o = count_q;

endmodule

// File: tb/tb_pdm_capture_controller.sv
// tb/tb_pdm_capture_controller.sv - directed self-checking bench for pdm_capture_controller
module tb_pdm_capture_controller;

    logic        clock_i;
    logic        reset_ni;
    logic        start_i;
    logic        stop_i;
    logic [15:0] length_i;
    logic        busy_o;
    logic        done_o;
    logic        overflow_o;
    logic [15:0] words_captured_o;
    logic        deser_enable_o;
    logic        deser_done_i;
    logic [15:0] deser_data_i;
    logic [15:0] data_o;
    logic        valid_o;
    logic        ready_i;

    int errors = 0;
    int checks = 0;
    logic [15:0] popq [$];

    pdm_capture_controller #(
        .WORD_LENGTH (16),
        .FIFO_DEPTH  (8),
        .COUNT_WIDTH (16)
    ) dut (
        .clock_i          (clock_i),
        .reset_ni         (reset_ni),
        .start_i          (start_i),
        .stop_i           (stop_i),
        .length_i         (length_i),
        .busy_o           (busy_o),
        .done_o           (done_o),
        .overflow_o       (overflow_o),
        .words_captured_o (words_captured_o),
        .deser_enable_o   (deser_enable_o),
        .deser_done_i     (deser_done_i),
        .deser_data_i     (deser_data_i),
        .data_o           (data_o),
        .valid_o          (valid_o),
        .ready_i          (ready_i)
    );

    initial clock_i = 1'b0;
    always #5 clock_i = ~clock_i;

    // Record every word the stream hands over; inputs only change just after posedge.
    always @(negedge clock_i) begin
        if (reset_ni && valid_o && ready_i) popq.push_back(data_o);
    end

    task automatic step();
        @(posedge clock_i);
        #1;
    endtask

    task automatic pulse_start(input logic [15:0] len);
        step();
        start_i  = 1'b1;
        length_i = len;
        step();
        start_i  = 1'b0;
    endtask

    task automatic pulse_stop();
        step();
        stop_i = 1'b1;
        step();
        stop_i = 1'b0;
    endtask

    task automatic pulse_word(input logic [15:0] w);
        step();
        deser_done_i = 1'b1;
        deser_data_i = w;
        step();
        deser_done_i = 1'b0;
    endtask

    task automatic wait_done(input int max_cycles, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            step();
            if (done_o) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset_ni = 1'b0; start_i = 1'b0; stop_i = 1'b0; length_i = '0;
        deser_done_i = 1'b0; deser_data_i = '0; ready_i = 1'b0;
        step(); step();
        checks++;
        if ({busy_o, done_o, overflow_o, deser_enable_o, valid_o} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags got %b expected 00000",
                     {busy_o, done_o, overflow_o, deser_enable_o, valid_o});
        end
        checks++;
        if (words_captured_o !== 16'h0 || data_o !== 16'h0) begin
            errors++;
            $display("FAIL reset_count_data got %h/%h expected 0000/0000", words_captured_o, data_o);
        end
        reset_ni = 1'b1;
        step();
    endtask

    task automatic test_length_stop();
        bit seen;
        logic [15:0] exp [4] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
        popq.delete();
        ready_i = 1'b1;
        pulse_start(16'd4);
        checks++;
        if (busy_o !== 1'b1 || deser_enable_o !== 1'b1) begin
            errors++;
            $display("FAIL len_capture_state got busy=%b en=%b expected 1/1", busy_o, deser_enable_o);
        end
        for (int i = 0; i < 4; i++) pulse_word(exp[i]);
        checks++;
        if (deser_enable_o !== 1'b0 || words_captured_o !== 16'd4) begin
            errors++;
            $display("FAIL len_exit got en=%b count=%0d expected 0/4", deser_enable_o, words_captured_o);
        end
        wait_done(20, seen);
        checks++;
        if (!seen || busy_o !== 1'b0 || words_captured_o !== 16'd4) begin
            errors++;
            $display("FAIL len_done got seen=%b busy=%b count=%0d expected 1/0/4",
                     seen, busy_o, words_captured_o);
        end
        checks++;
        if (popq.size() != 4) begin
            errors++;
            $display("FAIL len_words got %0d words expected 4", popq.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (popq[i] !== exp[i]) begin
                    errors++;
                    $display("FAIL len_word%0d got %h expected %h", i, popq[i], exp[i]);
                end
            end
        end
        step();
        checks++;
        if (done_o !== 1'b0) begin
            errors++;
            $display("FAIL len_done_width got %b expected 0", done_o);
        end
    endtask

    task automatic test_stop_unbounded();
        bit seen;
        popq.delete();
        ready_i = 1'b1;
        pulse_start(16'd0);
        pulse_word(16'hA001);
        pulse_word(16'hA002);
        pulse_word(16'hA003);
        pulse_stop();
        checks++;
        if (deser_enable_o !== 1'b0 || busy_o !== 1'b1) begin
            errors++;
            $display("FAIL stop_enable got en=%b busy=%b expected 0/1", deser_enable_o, busy_o);
        end
        wait_done(20, seen);
        checks++;
        if (!seen || valid_o !== 1'b0 || words_captured_o !== 16'd3) begin
            errors++;
            $display("FAIL stop_done got seen=%b valid=%b count=%0d expected 1/0/3",
                     seen, valid_o, words_captured_o);
        end
        checks++;
        if (popq.size() != 3 || popq[0] !== 16'hA001 || popq[2] !== 16'hA003) begin
            errors++;
            $display("FAIL stop_words got n=%0d first=%h expected 3 A001..A003",
                     popq.size(), (popq.size() > 0) ? popq[0] : 16'h0);
        end
    endtask

    task automatic test_overflow();
        bit seen;
        popq.delete();
        ready_i = 1'b0;
        pulse_start(16'd10);
        for (int i = 0; i < 10; i++) pulse_word(16'hB000 + 16'(i));
        checks++;
        if (overflow_o !== 1'b1 || words_captured_o !== 16'd8 || valid_o !== 1'b1) begin
            errors++;
            $display("FAIL ovf_state got ovf=%b count=%0d valid=%b expected 1/8/1",
                     overflow_o, words_captured_o, valid_o);
        end
        checks++;
        if (data_o !== 16'hB000) begin
            errors++;
            $display("FAIL ovf_head_stable got %h expected b000", data_o);
        end
        pulse_stop();
        ready_i = 1'b1;
        wait_done(30, seen);
        checks++;
        if (!seen || overflow_o !== 1'b1) begin
            errors++;
            $display("FAIL ovf_done got seen=%b ovf=%b expected 1/1", seen, overflow_o);
        end
        checks++;
        if (popq.size() != 8 || popq[0] !== 16'hB000 || popq[7] !== 16'hB007) begin
            errors++;
            $display("FAIL ovf_words got n=%0d expected 8 words b000..b007", popq.size());
        end
    endtask

    task automatic test_full_pop();
        bit seen;
        popq.delete();
        ready_i = 1'b0;
        pulse_start(16'd0);
        checks++;
        if (overflow_o !== 1'b0) begin
            errors++;
            $display("FAIL full_ovf_cleared got %b expected 0", overflow_o);
        end
        for (int i = 0; i < 8; i++) pulse_word(16'hC000 + 16'(i));
        step();
        ready_i      = 1'b1;
        deser_done_i = 1'b1;
        deser_data_i = 16'hC008;
        step();
        deser_done_i = 1'b0;
        checks++;
        if (overflow_o !== 1'b0 || words_captured_o !== 16'd9) begin
            errors++;
            $display("FAIL full_pop_push got ovf=%b count=%0d expected 0/9",
                     overflow_o, words_captured_o);
        end
        pulse_stop();
        wait_done(30, seen);
        checks++;
        if (!seen || popq.size() != 9) begin
            errors++;
            $display("FAIL full_pop_drain got seen=%b n=%0d expected 1/9", seen, popq.size());
        end else begin
            for (int i = 0; i < 9; i++) begin
                checks++;
                if (popq[i] !== 16'hC000 + 16'(i)) begin
                    errors++;
                    $display("FAIL full_word%0d got %h expected %h", i, popq[i], 16'hC000 + 16'(i));
                end
            end
        end
    endtask

    task automatic test_async_reset();
        ready_i = 1'b0;
        pulse_start(16'd0);
        pulse_word(16'hD001);
        pulse_word(16'hD002);
        pulse_word(16'hD003);
        #2;
        reset_ni = 1'b0;
        #1;
        checks++;
        if ({busy_o, deser_enable_o, valid_o, overflow_o} !== 4'b0 ||
            words_captured_o !== 16'h0 || data_o !== 16'h0) begin
            errors++;
            $display("FAIL areset_outputs got flags=%b count=%0d data=%h expected 0/0/0",
                     {busy_o, deser_enable_o, valid_o, overflow_o}, words_captured_o, data_o);
        end
        step();
        reset_ni = 1'b1;
        step();
        checks++;
        if (valid_o !== 1'b0 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL areset_release got valid=%b busy=%b expected 0/0", valid_o, busy_o);
        end
    endtask

    task automatic test_start_ignored();
        bit seen;
        ready_i = 1'b1;
        pulse_start(16'd3);
        pulse_word(16'hE001);
        pulse_start(16'd7);
        checks++;
        if (busy_o !== 1'b1 || words_captured_o !== 16'd1) begin
            errors++;
            $display("FAIL restart_ignored got busy=%b count=%0d expected 1/1", busy_o, words_captured_o);
        end
        pulse_word(16'hE002);
        pulse_word(16'hE003);
        checks++;
        if (deser_enable_o !== 1'b0 || words_captured_o !== 16'd3) begin
            errors++;
            $display("FAIL restart_length_kept got en=%b count=%0d expected 0/3",
                     deser_enable_o, words_captured_o);
        end
        wait_done(20, seen);
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL restart_done got %b expected 1", seen);
        end
    endtask

    initial begin
        test_reset();
        test_length_stop();
        test_stop_unbounded();
        test_overflow();
        test_full_pop();
        test_async_reset();
        test_start_ignored();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
